// File: rtl/osc_trig_capture.sv
// Oscilloscope trigger/capture engine: circular sample RAM with pre-trigger window,
// edge trigger with optional auto-trigger timeout, and oldest-first record readout.
module osc_trig_capture #(
    parameter int DW    = 8,
    parameter int DEPTH = 1024,
    parameter int TOW   = 27,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic signed [DW-1:0] din,
    input  logic                 en,
    input  logic                 start,
    input  logic                 abort,
    input  logic signed [DW-1:0] level,
    input  logic [1:0]           edge_sel,
    input  logic [AW-1:0]        hpos,
    input  logic [TOW-1:0]       to,
    output logic                 busy,
    output logic                 ready,
    output logic                 trig_flag,
    input  logic                 rd,
    output logic signed [DW-1:0] rd_data,
    output logic                 rd_valid,
    output logic                 rd_last
);

    typedef enum logic [2:0] {S_IDLE, S_PRE, S_WAIT, S_POST, S_DONE} state_t;

    state_t               state;
    logic signed [DW-1:0] mem [DEPTH];
    logic [AW-1:0]        wptr, tptr, rcnt, cnt, hpos_r;
    logic [TOW-1:0]       tocnt, to_r;
    logic signed [DW-1:0] lvl_r, prev;
    logic [1:0]           edge_r;
    logic                 hist_ok;

    function automatic logic edge_hit(input logic signed [DW-1:0] p, c, l,
                                      input logic [1:0] sel);
        logic rise, fall;
        rise = (p < l) && (c >= l);
        fall = (p >= l) && (c < l);
        case (sel)
            2'd0:    return rise;
            2'd1:    return fall;
            default: return rise | fall;
        endcase
    endfunction

    logic          capturing, arm, wr_en, trig, to_hit;
    logic [AW-1:0] post_len, raddr;

    assign capturing = (state == S_PRE) || (state == S_WAIT) || (state == S_POST);
    assign arm       = start && !abort && !rst && ((state == S_IDLE) || (state == S_DONE));
    // DEPTH is a power of two, so DEPTH-1-hpos is the bitwise complement
    assign post_len  = ~hpos_r;
    assign wr_en     = en && capturing && !abort && !rst &&
                       !((state == S_POST) && (post_len == '0));
    assign trig      = en && hist_ok && (state == S_WAIT) && edge_hit(prev, din, lvl_r, edge_r);
    assign to_hit    = en && (state == S_WAIT) && (to_r != '0) && ((tocnt + TOW'(1)) == to_r);
    assign raddr     = tptr - hpos_r + rcnt;

    // Sample RAM write port and trigger configuration (data path, not reset)
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wptr] <= din;
        if (en)
            prev <= din;
        if (arm) begin
            lvl_r  <= level;
            edge_r <= edge_sel;
            hpos_r <= hpos;
            to_r   <= to;
        end
    end

    // Control FSM and readout stage
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            ready     <= 1'b0;
            trig_flag <= 1'b0;
            rd_valid  <= 1'b0;
            rd_last   <= 1'b0;
            rd_data   <= '0;
            wptr      <= '0;
            tptr      <= '0;
            rcnt      <= '0;
            cnt       <= '0;
            tocnt     <= '0;
            hist_ok   <= 1'b0;
        end else begin
            rd_valid <= 1'b0;
            rd_last  <= 1'b0;
            if (wr_en)
                wptr <= wptr + AW'(1);
            if (en && capturing)
                hist_ok <= 1'b1;

            if (abort) begin
                state <= S_IDLE;
                busy  <= 1'b0;
                ready <= 1'b0;
            end else if (arm) begin
                trig_flag <= 1'b0;
                cnt       <= '0;
                tocnt     <= '0;
                rcnt      <= '0;
                wptr      <= '0;
                hist_ok   <= 1'b0;
                busy      <= 1'b1;
                ready     <= 1'b0;
                state     <= (hpos != '0) ? S_PRE : S_WAIT;
            end else begin
                case (state)
                    S_PRE: begin
                        if (en) begin
                            cnt <= cnt + AW'(1);
                            if ((cnt + AW'(1)) == hpos_r)
                                state <= S_WAIT;
                        end
                    end
                    S_WAIT: begin
                        if (trig) begin
                            trig_flag <= 1'b1;
                            tptr      <= wptr;
                            cnt       <= '0;
                            state     <= S_POST;
                        end else if (en && (to_r != '0)) begin
                            tocnt <= tocnt + TOW'(1);
                            if (to_hit) begin
                                tptr  <= wptr;
                                cnt   <= '0;
                                state <= S_POST;
                            end
                        end
                    end
                    S_POST: begin
                        if (post_len == '0) begin
                            state <= S_DONE;
                            busy  <= 1'b0;
                            ready <= 1'b1;
                        end else if (en) begin
                            cnt <= cnt + AW'(1);
                            if ((cnt + AW'(1)) == post_len) begin
                                state <= S_DONE;
                                busy  <= 1'b0;
                                ready <= 1'b1;
                            end
                        end
                    end
                    S_DONE: begin
                        if (rd) begin
                            rd_data  <= mem[raddr];
                            rd_valid <= 1'b1;
                            rcnt     <= rcnt + AW'(1);
                            if (rcnt == AW'(DEPTH - 1)) begin
                                rd_last <= 1'b1;
                                ready   <= 1'b0;
                                state   <= S_IDLE;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_osc_trig_capture.sv
// Bench for osc_trig_capture: logs every strobed sample, derives the expected record
// in sample-index space and scoreboards the readout stream against it.
module tb_osc_trig_capture;

    localparam int DW = 8, DEPTH = 1024, TOW = 27, AW = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst = 1'b1;
    logic signed [DW-1:0] din = '0;
    logic                 en = 1'b0, start = 1'b0, abort = 1'b0, rd = 1'b0;
    logic signed [DW-1:0] level = '0;
    logic [1:0]           edge_sel = '0;
    logic [AW-1:0]        hpos = '0;
    logic [TOW-1:0]       to = '0;
    logic                 busy, ready, trig_flag, rd_valid, rd_last;
    logic signed [DW-1:0] rd_data;

    osc_trig_capture #(.DW(DW), .DEPTH(DEPTH), .TOW(TOW)) dut (
        .clk(clk), .rst(rst), .din(din), .en(en), .start(start), .abort(abort),
        .level(level), .edge_sel(edge_sel), .hpos(hpos), .to(to),
        .busy(busy), .ready(ready), .trig_flag(trig_flag),
        .rd(rd), .rd_data(rd_data), .rd_valid(rd_valid), .rd_last(rd_last)
    );

    int nchk = 0, nerr = 0;
    int log_s[$];
    int log_t[$];
    int exp_q[$];
    int got[DEPTH];
    int sidx = 0, tick_n = 0, gcount = 0, en_div = 1, phase = 0, rd_idx = 0;

    task automatic check_val(input string tag, input int act, input int exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    function automatic int sine(input int g);
        return int'(120.0 * $sin(2.0 * 3.14159265358979 * g / 256.0));
    endfunction

    function automatic bit edge_m(input int p, input int c, input int l, input int s);
        bit r, f;
        r = (p < l) && (c >= l);
        f = (p >= l) && (c < l);
        if (s == 0) return r;
        if (s == 1) return f;
        return r | f;
    endfunction

    // One clock: drive inputs, strobe a sine sample every en_div clocks, then monitor readout
    task automatic tick(input logic st, input logic ab, input logic r, input logic note);
        start = st;
        abort = ab;
        rd    = r;
        tick_n++;
        en    = (phase == 0);
        phase = (phase + 1) % en_div;
        if (en) begin
            din = DW'(sine(gcount));
            gcount++;
            log_s.push_back(int'(din));
            log_t.push_back(tick_n);
        end else begin
            din = DW'($urandom);
        end
        if (note) sidx = log_s.size();
        @(posedge clk);
        #1;
        if (rd_valid) begin
            if (exp_q.size() == 0) begin
                check_val("spurious_rd_valid", 1, 0);
            end else begin
                int e;
                e = exp_q.pop_front();
                check_val("rd_data", int'(rd_data), e);
                check_val("rd_last", int'(rd_last), int'(rd_idx == DEPTH - 1));
                if (rd_idx < DEPTH) got[rd_idx] = int'(rd_data);
                rd_idx++;
            end
        end
    endtask

    task automatic arm(input int hp, input int tov, input int lvl, input int sel, input int div);
        en_div   = div;
        phase    = 0;
        hpos     = AW'(hp);
        to       = TOW'(tov);
        level    = DW'(lvl);
        edge_sel = 2'(sel);
        tick(1'b1, 1'b0, 1'b0, 1'b1);
        check_val("busy_after_start", int'(busy), 1);
    endtask

    // Reference: first WAIT index with a valid edge, or the to-th WAIT strobe
    task automatic model(input int hp, input int tov, input int lvl, input int sel,
                         output int t, output int tf);
        t  = -1;
        tf = 0;
        for (int k = hp; sidx + k < log_s.size(); k++) begin
            if (k >= 1 && edge_m(log_s[sidx + k - 1], log_s[sidx + k], lvl, sel)) begin
                t  = k;
                tf = 1;
                break;
            end
            if (tov != 0 && (k - hp + 1) == tov) begin
                t = k;
                break;
            end
        end
    endtask

    task automatic finish(input int hp, input int tov, input int lvl, input int sel,
                          output int t, output int rt);
        int n, tf, idx;
        n  = 0;
        rt = -1;
        while (!ready && n < 20000) begin
            tick(1'b0, 1'b0, 1'b0, 1'b0);
            n++;
        end
        if (ready) rt = tick_n;
        else check_val("ready_timeout", 0, 1);
        model(hp, tov, lvl, sel, t, tf);
        check_val("trig_flag", int'(trig_flag), tf);
        if (t < 0) begin
            check_val("model_found_event", t, 0);
        end else begin
            rd_idx = 0;
            exp_q.delete();
            for (int i = 0; i < DEPTH; i++) begin
                idx = sidx + t - hp + i;
                exp_q.push_back((idx < log_s.size()) ? log_s[idx] : 9999);
                tick(1'b0, 1'b0, 1'b1, 1'b0);
            end
            tick(1'b0, 1'b0, 1'b0, 1'b0);
            tick(1'b0, 1'b0, 1'b0, 1'b0);
            check_val("reads_returned", rd_idx, DEPTH);
            check_val("ready_after_read", int'(ready), 0);
        end
    endtask

    initial begin
        int t, rt, bad, n;

        rst = 1'b1;
        repeat (3) tick(1'b0, 1'b0, 1'b0, 1'b0);
        check_val("rst_busy", int'(busy), 0);
        check_val("rst_ready", int'(ready), 0);
        check_val("rst_trig_flag", int'(trig_flag), 0);
        check_val("rst_rd_valid", int'(rd_valid), 0);
        check_val("rst_rd_last", int'(rd_last), 0);
        check_val("rst_rd_data", int'(rd_data), 0);
        rst = 1'b0;
        tick(1'b0, 1'b0, 1'b0, 1'b0);

        tick(1'b0, 1'b0, 1'b1, 1'b0);
        check_val("idle_rd_valid", int'(rd_valid), 0);

        // Rising edge, level 100, en every 4 clocks
        arm(250, 300, 100, 0, 4);
        finish(250, 300, 100, 0, t, rt);
        check_val("rise_pre_below", int'(got[249] < 100), 1);
        check_val("rise_trig_above", int'(got[250] >= 100), 1);

        // Falling edge, level 50
        arm(250, 300, 50, 1, 4);
        finish(250, 300, 50, 1, t, rt);
        check_val("fall_pre_above", int'(got[249] >= 50), 1);
        check_val("fall_trig_below", int'(got[250] < 50), 1);

        // Unreachable level: timeout on the 300th WAIT strobe; start in WAIT is ignored
        arm(750, 300, -128, 0, 1);
        repeat (760) tick(1'b0, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        finish(750, 300, -128, 0, t, rt);
        check_val("timeout_flag_clear", int'(trig_flag), 0);
        check_val("timeout_idx750", got[750], log_s[sidx + 750 + 299]);

        // No trigger, no timeout: stays busy until abort
        arm(0, 0, -128, 2, 1);
        bad = 0;
        for (int i = 0; i < 10000; i++) begin
            tick(1'b0, 1'b0, 1'b0, 1'b0);
            if (!busy || ready) bad = 1;
        end
        check_val("forever_busy_hold", bad, 0);
        tick(1'b0, 1'b1, 1'b0, 1'b0);
        check_val("abort_busy", int'(busy), 0);
        check_val("abort_ready", int'(ready), 0);
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        check_val("abort_stays_idle", int'(busy), 0);

        // hpos = 0: trigger at index 0, POST writes 1023 samples
        arm(0, 0, 100, 0, 1);
        finish(0, 0, 100, 0, t, rt);
        check_val("hpos0_trig_sample", int'(got[0] >= 100), 1);
        if (t >= 0) check_val("hpos0_ready_tick", rt, log_t[sidx + t] + DEPTH - 1);

        // hpos = DEPTH-1: trigger at index 1023, DONE one cycle after the trigger
        arm(DEPTH - 1, 0, 100, 0, 1);
        finish(DEPTH - 1, 0, 100, 0, t, rt);
        check_val("hposmax_trig_sample", int'(got[DEPTH - 1] >= 100), 1);
        check_val("hposmax_pre_sample", int'(got[DEPTH - 2] < 100), 1);
        if (t >= 0) check_val("hposmax_ready_tick", rt, log_t[sidx + t] + 1);

        // Abort in POST keeps trig_flag
        arm(0, 0, 100, 0, 1);
        n = 0;
        while (!trig_flag && n < 2000) begin
            tick(1'b0, 1'b0, 1'b0, 1'b0);
            n++;
        end
        check_val("post_trig_seen", int'(trig_flag), 1);
        check_val("post_busy", int'(busy), 1);
        tick(1'b0, 1'b1, 1'b0, 1'b0);
        check_val("post_abort_busy", int'(busy), 0);
        check_val("post_abort_flag_held", int'(trig_flag), 1);
        check_val("post_abort_ready", int'(ready), 0);

        // Reset in POST
        arm(0, 0, 100, 0, 1);
        n = 0;
        while (!trig_flag && n < 2000) begin
            tick(1'b0, 1'b0, 1'b0, 1'b0);
            n++;
        end
        check_val("rstpost_trig_seen", int'(trig_flag), 1);
        rst = 1'b1;
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        check_val("rstpost_busy", int'(busy), 0);
        check_val("rstpost_ready", int'(ready), 0);
        check_val("rstpost_trig_flag", int'(trig_flag), 0);
        check_val("rstpost_rd_valid", int'(rd_valid), 0);
        check_val("rstpost_rd_last", int'(rd_last), 0);
        check_val("rstpost_rd_data", int'(rd_data), 0);
        rst = 1'b0;
        tick(1'b0, 1'b0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule

// File: doc/osc_trig_capture.md
Name: osc_trig_capture

Overview:
- Parametrised oscilloscope trigger/capture engine with a generic sample width, a power-of-two record depth and a selectable trigger edge.
- Owns a circular sample RAM. Captures one record of DEPTH samples with a programmable pre-trigger position (hpos) and an optional auto-trigger timeout.
- The record is read back oldest-first, with the trigger sample at index hpos.
- Sits between the ADC sample stream (strobed by en) and the host readout logic.

Parameters:
- DW, 8: sample width, signed two's complement.
- DEPTH, 1024: record length in samples; must be a power of two, at least 4.
- TOW, 27: width of the timeout value.
- AW, $clog2(DEPTH): address/position width (derived; do not override).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- din  in  DW  signed sample
- en  in  1  sample strobe; din is valid when en=1
- start  in  1  arm a new capture (single-cycle pulse)
- abort  in  1  cancel the capture or readout; return to IDLE
- level  in  DW  signed trigger level, latched at start
- edge_sel  in  2  trigger edge, latched at start: 0 = rising, 1 = falling, 2/3 = either
- hpos  in  AW  pre-trigger sample count, latched at start; range 0..DEPTH-1
- to  in  TOW  timeout in en-strobes while in WAIT, latched at start; 0 = wait forever
- busy  out  1  high in PRE, WAIT and POST
- ready  out  1  high in DONE (record available)
- trig_flag  out  1  1 = record was ended by a real trigger; 0 = timeout or never triggered
- rd  in  1  read request; honoured only in DONE
- rd_data  out  DW  read data
- rd_valid  out  1  rd_data qualifier
- rd_last  out  1  high together with rd_valid on the DEPTH-th sample

Behaviour:
- Reset values: state=IDLE; busy, ready, trig_flag, rd_valid and rd_last are 0; rd_data=0; all counters/pointers are 0. RAM contents are undefined.
- Write path:
  - In PRE, WAIT and POST, each en writes din to RAM[wptr], then wptr <= wptr+1 (mod DEPTH, natural wrap).
  - No writes occur in IDLE or DONE.
- Edge detector:
  - prev holds the last strobed din; hist_ok is set after the first en following start.
  - rising = prev<level && din>=level; falling = prev>=level && din<level (signed compares).
  - trig = en && hist_ok && selected edge && state==WAIT.
- States:
  - IDLE: start -> clear trig_flag and counters, latch level/edge_sel/hpos/to. Go to PRE if hpos>0, else WAIT. rd is ignored.
  - PRE: count en writes; on the write that makes cnt==hpos, go to WAIT.
  - WAIT:
    - On trig: set trig_flag=1, tptr <= wptr (the trigger sample's address), go to POST.
    - Else, if to!=0 and en makes the timeout count ==to: tptr <= wptr of that sample, trig_flag stays 0, go to POST.
    - WAIT overwrites circularly, so the pre-trigger window always holds the latest hpos samples.
  - POST: after DEPTH-hpos-1 further en writes, go to DONE. If DEPTH-hpos-1==0, go to DONE on the next cycle.
  - DONE:
    - Readout address base = tptr-hpos (mod DEPTH).
    - Each rd reads RAM[base+rcnt]; rd_data/rd_valid follow one cycle later; rcnt increments.
    - rd_last accompanies rcnt==DEPTH-1; the cycle after that read the block goes to IDLE.
    - start in DONE discards the record and re-arms as from IDLE.
- Simultaneous events and boundaries:
  - abort has priority over everything: state goes to IDLE; trig_flag is held; no further RAM writes.
  - start while busy is ignored. rd outside DONE is ignored (rd_valid stays 0).
  - If trig and the timeout coincide, the trigger wins (trig_flag=1).
  - rst mid-capture or mid-readout returns to the reset state within one cycle.
- busy/ready are registered decodes of state; they change on the clock edge the state changes.

Test Plan:
- Sine of period 256 samples, en every 4 clocks; start with level=100, rising, hpos=250, to=300. Required: trig_flag=1, ready rises, 1024 reads return a record with sample[249]<100 and sample[250]>=100; rd_last is only on the 1024th read.
- Same stimulus, edge_sel=1 (falling), level=50. Required: sample[249]>=50, sample[250]<50, trig_flag=1.
- level=-128 (unreachable edge), to=300, hpos=750. Required: timeout after exactly 300 WAIT strobes, trig_flag=0, record index 750 is the 300th WAIT sample, all 1024 samples are contiguous.
- level=-128, to=0. Required: busy stays high for 10000 strobes and ready stays 0. Then abort: busy=0 the next cycle and wptr is frozen.
- hpos=0 and hpos=DEPTH-1 corner cases. Required: trigger sample lands at index 0 (POST writes 1023) and at index 1023 (DONE one cycle after the trigger), respectively.
- start pulsed during WAIT is ignored. rd pulsed in IDLE gives rd_valid=0. rst asserted in POST returns every output to its reset value on the next clock edge.
